placar: RTL and testbench

Game-state and score keeper sitting directly downstream of the entity layer. Consumes the enemy alive vector, the loss flag and the lives count. Produces:
- the BCD score, high score, wave number and game state;
- the `reiniciarJogo` restart pulse that the entity layer's `nave`, `fileira` and `bola` instances take as input.

Optionally drives four seven-segment displays with the score.

---
 rtl/jogo_pkg.sv | 32 +++
 rtl/placar_if.sv | 38 +++
 rtl/hex7seg.sv | 30 +++
 rtl/placar.sv | 181 ++++++++++++++++++
 tb/tb_placar.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the game-state keeper: state encodings, BCD width,
// seven-segment blank pattern and a small binary-to-BCD helper.
package jogo_pkg;

  typedef enum logic [1:0] {
    JOGANDO     = 2'b00,
    ONDA_LIMPA  = 2'b01,
    FIM_DE_JOGO = 2'b10,
    REINICIO    = 2'b11
  } estado_t;

  localparam int BCD_W   = 16;
  localparam int DIGITOS = BCD_W / 4;

  localparam logic [6:0] SEG_APAGADO = 7'h7F;

  // Binary 0..99 to two packed BCD digits {tens, ones}.
  function automatic logic [7:0] bin2bcd2(input logic [6:0] v);
    logic [3:0] dez;
    logic [6:0] resto;
    dez   = '0;
    resto = v;
    for (int i = 0; i < 9; i++) begin
      if (resto >= 7'd10) begin
        resto = resto - 7'd10;
        dez   = dez + 4'd1;
      end
    end
    return {dez, resto[3:0]};
  endfunction

endpackage

// File: rtl/placar_if.sv
// Bundle between the entity layer and the score keeper. The entity layer
// (master) drives the game inputs; placar (slave) drives score, state and
// display outputs.
interface placar_if #(
  parameter int N_INIMIGOS = 5
);
  import jogo_pkg::*;

  logic                  pausa;
  logic                  iniciar;
  logic [0:N_INIMIGOS-1] inimigo_vivo_array;
  logic                  perdeu;
  logic [1:0]            vidas;

  logic [BCD_W-1:0]      pontos;
  logic [BCD_W-1:0]      recorde;
  logic [3:0]            nivel;
  logic [1:0]            estado;
  logic                  nova_onda;
  logic                  reiniciarJogo;
  logic [6:0]            HEX0;
  logic [6:0]            HEX1;
  logic [6:0]            HEX2;
  logic [6:0]            HEX3;

  modport master (
    output pausa, iniciar, inimigo_vivo_array, perdeu, vidas,
    input  pontos, recorde, nivel, estado, nova_onda, reiniciarJogo,
           HEX0, HEX1, HEX2, HEX3
  );

  modport slave (
    input  pausa, iniciar, inimigo_vivo_array, perdeu, vidas,
    output pontos, recorde, nivel, estado, nova_onda, reiniciarJogo,
           HEX0, HEX1, HEX2, HEX3
  );

endinterface

// File: rtl/hex7seg.sv
// One BCD digit to active-low seven segments (bit 0 = segment a).
// Only compiled when PLACAR_HEX_EN is defined, so the default build carries
// no decoder at all.
`ifdef PLACAR_HEX_EN
module hex7seg
  import jogo_pkg::*;
(
  input  logic [3:0] digito,
  output logic [6:0] seg
);

  // Digit lookup; anything outside 0..9 is blanked.
  always_comb begin
    unique case (digito)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_APAGADO;
    endcase
  end

endmodule
`endif

// File: rtl/placar.sv
// Game-state and score keeper downstream of the entity layer.
// The alive vector and loss flag are registered once on entry; kills are
// the falling bits between that register and the one behind it, so a vector
// change sampled at edge k shows in the score after edge k+1.
// Optional seven-segment output under macro PLACAR_HEX_EN.
module placar
  import jogo_pkg::*;
#(
  parameter int N_INIMIGOS       = 5,
  parameter int PONTOS_POR_ABATE = 1,
  parameter int PULSO_REINICIO   = 4
) (
  input  logic     CLOCK_50,
  input  logic     reset,
  placar_if.slave  bus
);

  localparam int CNT_W = (PULSO_REINICIO > 1) ? $clog2(PULSO_REINICIO) : 1;
  localparam int POP_W = $clog2(N_INIMIGOS + 1);

  estado_t                 estado, estado_next;
  logic [0:N_INIMIGOS-1]   vivo_r, vivo_ant, abates;
  logic                    perdeu_r, ant_valido;
  logic [BCD_W-1:0]        pontos, recorde, pontos_soma;
  logic [3:0]              nivel;
  logic                    nova_onda, reinicio_pulso;
  logic [CNT_W-1:0]        cnt;
  logic [POP_W-1:0]        abates_qtd;
  logic [6:0]              incremento;
  logic [7:0]              inc_bcd;
  logic                    pontua, limpa_onda, entra_reinicio, fim_pulso;

  // Respawn (rising bits) never produces a kill.
  assign abates = vivo_ant & ~vivo_r;

  // Kill count and its value in points, as two BCD digits.
  always_comb begin
    abates_qtd = '0;
    for (int i = 0; i < N_INIMIGOS; i++)
      abates_qtd = abates_qtd + POP_W'(abates[i]);
  end

  assign incremento = 7'(abates_qtd * PONTOS_POR_ABATE);
  assign inc_bcd    = bin2bcd2(incremento);

  // Digit-serial BCD add; a carry out of the top digit saturates at 9999.
  always_comb begin
    logic [4:0] soma_dig;
    logic [3:0] parcela;
    logic       carry;
    pontos_soma = '0;
    carry       = 1'b0;
    for (int d = 0; d < DIGITOS; d++) begin
      if (d == 0)      parcela = inc_bcd[3:0];
      else if (d == 1) parcela = inc_bcd[7:4];
      else             parcela = 4'd0;
      soma_dig = {1'b0, pontos[4*d +: 4]} + {1'b0, parcela} + {4'd0, carry};
      if (soma_dig > 5'd9) begin
        soma_dig = soma_dig + 5'd6;
        carry    = 1'b1;
      end else begin
        carry    = 1'b0;
      end
      pontos_soma[4*d +: 4] = soma_dig[3:0];
    end
    if (carry) pontos_soma = {DIGITOS{4'h9}};
  end

  // Game FSM state register.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: non-blocking so every register samples pre-edge values together.
    if (reset) estado <= JOGANDO;
    else       estado <= estado_next;
  end

  // Next state and per-cycle events; pausa freezes all of it.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    estado_next    = estado;
    pontua         = 1'b0;
    limpa_onda     = 1'b0;
    entra_reinicio = 1'b0;
    fim_pulso      = 1'b0;
    if (!bus.pausa) begin
      unique case (estado)
        JOGANDO: begin
          pontua = ant_valido;
          if (perdeu_r) begin
            estado_next = FIM_DE_JOGO;
          end else if (vivo_r == '0 && vivo_ant != '0) begin
            estado_next = ONDA_LIMPA;
            limpa_onda  = 1'b1;
          end
        end
        ONDA_LIMPA: begin
          if (perdeu_r)          estado_next = FIM_DE_JOGO;
          else if (vivo_r != '0) estado_next = JOGANDO;
        end
        FIM_DE_JOGO: begin
          if (bus.iniciar) begin
            estado_next    = REINICIO;
            entra_reinicio = 1'b1;
          end
        end
        REINICIO: begin
          if (cnt == '0) begin
            estado_next = JOGANDO;
            fim_pulso   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Input stage, score, level, high score and restart pulse registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      vivo_r         <= '0;
      vivo_ant       <= '0;
      perdeu_r       <= 1'b0;
      ant_valido     <= 1'b0;
      pontos         <= '0;
      recorde        <= '0;
      nivel          <= 4'd1;
      nova_onda      <= 1'b0;
      reinicio_pulso <= 1'b0;
      cnt            <= '0;
    end else begin
      vivo_r     <= bus.inimigo_vivo_array;
      vivo_ant   <= vivo_r;
      perdeu_r   <= bus.perdeu;
      // Valid again one clock after leaving REINICIO (or reset).
      ant_valido <= (estado != REINICIO) && !entra_reinicio;
      nova_onda  <= limpa_onda;
      if (pontua) pontos <= pontos_soma;
      if (limpa_onda && nivel != 4'd15) nivel <= nivel + 4'd1;
      // Packed BCD orders exactly like binary, so a plain compare suffices.
      if (estado == FIM_DE_JOGO && pontos > recorde) recorde <= pontos;
      if (entra_reinicio) begin
        pontos         <= '0;
        nivel          <= 4'd1;
        reinicio_pulso <= 1'b1;
        cnt            <= CNT_W'(PULSO_REINICIO - 1);
      end else if (fim_pulso) begin
        reinicio_pulso <= 1'b0;
      end else if (estado == REINICIO && !bus.pausa) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign bus.pontos        = pontos;
  assign bus.recorde       = recorde;
  assign bus.nivel         = nivel;
  assign bus.estado        = estado;
  assign bus.nova_onda     = nova_onda;
  assign bus.reiniciarJogo = reinicio_pulso;

`ifdef PLACAR_HEX_EN
  logic [BCD_W-1:0] mostra;

  // Game over shows the high score on all digits; otherwise lives + score.
  assign mostra = (estado == FIM_DE_JOGO) ? recorde
                                          : {2'b00, bus.vidas, pontos[11:0]};

  hex7seg u_hex0 (.digito(mostra[3:0]),   .seg(bus.HEX0));
  hex7seg u_hex1 (.digito(mostra[7:4]),   .seg(bus.HEX1));
  hex7seg u_hex2 (.digito(mostra[11:8]),  .seg(bus.HEX2));
  hex7seg u_hex3 (.digito(mostra[15:12]), .seg(bus.HEX3));
`else
  logic unused_vidas;
  assign unused_vidas = ^bus.vidas;

  assign bus.HEX0 = SEG_APAGADO;
  assign bus.HEX1 = SEG_APAGADO;
  assign bus.HEX2 = SEG_APAGADO;
  assign bus.HEX3 = SEG_APAGADO;
`endif

endmodule

// File: tb/tb_placar.sv
// Bench for placar: two instances (1 and 9 points per kill) share one
// stimulus stream; a behavioural model keeps the score as a plain integer
// and the game phase as a number, and every cycle is compared against it.
module tb_placar;

  localparam int N     = 5;
  localparam int PULSO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  placar_if #(.N_INIMIGOS(N)) bus_a ();
  placar_if #(.N_INIMIGOS(N)) bus_b ();

  placar #(.N_INIMIGOS(N), .PONTOS_POR_ABATE(1), .PULSO_REINICIO(PULSO)) u_a (
    .CLOCK_50(clk), .reset(rst), .bus(bus_a)
  );
  placar #(.N_INIMIGOS(N), .PONTOS_POR_ABATE(9), .PULSO_REINICIO(PULSO)) u_b (
    .CLOCK_50(clk), .reset(rst), .bus(bus_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 playing, 1 wave cleared, 2 game over, 3 restarting.
  logic [0:N-1] m_vr, m_va;
  bit           m_pr, m_av, m_nova, m_rj;
  int           m_est, m_niv, m_left;
  int           m_pts [2];
  int           m_rec [2];
  int           ppk   [2] = '{1, 9};
  logic [1:0]   vidas_cur;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  default: return 7'h7F;
    endcase
  endfunction

  task automatic model(input logic [0:N-1] vec, input bit perd, pau, ini, r);
    int  kills, nest;
    bit  enter, nova;
    if (r) begin
      m_vr = '0; m_va = '0; m_pr = 0; m_av = 0; m_nova = 0; m_rj = 0;
      m_est = 0; m_niv = 1; m_left = 0;
      m_pts = '{0, 0}; m_rec = '{0, 0};
      return;
    end
    kills = $countones(m_va & ~m_vr);
    nest  = m_est;
    enter = 0;
    nova  = 0;
    if (m_est == 2)
      for (int k = 0; k < 2; k++) if (m_pts[k] > m_rec[k]) m_rec[k] = m_pts[k];
    if (!pau) begin
      case (m_est)
        0: begin
          if (m_av)
            for (int k = 0; k < 2; k++) begin
              m_pts[k] = m_pts[k] + kills * ppk[k];
              if (m_pts[k] > 9999) m_pts[k] = 9999;
            end
          if (m_pr) nest = 2;
          else if (m_vr == 0 && m_va != 0) begin
            nest = 1; nova = 1;
            if (m_niv < 15) m_niv++;
          end
        end
        1: if (m_pr) nest = 2; else if (m_vr != 0) nest = 0;
        2: if (ini) begin
          nest = 3; enter = 1; m_left = PULSO; m_rj = 1;
          m_pts = '{0, 0}; m_niv = 1;
        end
        default: begin
          m_left--;
          if (m_left == 0) begin nest = 0; m_rj = 0; end
        end
      endcase
    end
    m_av   = (m_est != 3) && !enter;
    m_est  = nest;
    m_nova = nova;
    m_va   = m_vr;
    m_vr   = vec;
    m_pr   = perd;
  endtask

  function automatic logic [27:0] exp_hex(input int k);
`ifdef PLACAR_HEX_EN
    logic [15:0] d;
    if (m_est == 2) d = to_bcd(m_rec[k]);
    else begin
      d = to_bcd(m_pts[k]);
      d[15:12] = {2'b00, vidas_cur};
    end
    return {seg7(d[15:12]), seg7(d[11:8]), seg7(d[7:4]), seg7(d[3:0])};
`else
    return {4{7'h7F}};
`endif
  endfunction

  task automatic compare_all();
    check("pontos_a",  bus_a.pontos,  to_bcd(m_pts[0]));
    check("pontos_b",  bus_b.pontos,  to_bcd(m_pts[1]));
    check("recorde_a", bus_a.recorde, to_bcd(m_rec[0]));
    check("recorde_b", bus_b.recorde, to_bcd(m_rec[1]));
    check("nivel",     bus_a.nivel,   m_niv);
    check("estado_a",  bus_a.estado,  m_est);
    check("estado_b",  bus_b.estado,  m_est);
    check("nova_onda", bus_a.nova_onda, m_nova);
    check("reiniciar", bus_a.reiniciarJogo, m_rj);
    check("reiniciar_b", bus_b.reiniciarJogo, m_rj);
    check("hex_a", {bus_a.HEX3, bus_a.HEX2, bus_a.HEX1, bus_a.HEX0}, exp_hex(0));
    check("hex_b", {bus_b.HEX3, bus_b.HEX2, bus_b.HEX1, bus_b.HEX0}, exp_hex(1));
  endtask

  // One clock: drive at the falling edge, update model at the rising edge,
  // compare 1 time unit later.
  task automatic step(input logic [0:N-1] vec, input bit perd = 0, input bit pau = 0,
                      input bit ini = 0, input bit r = 0);
    @(negedge clk);
    vidas_cur = 2'($urandom);
    rst = r;
    bus_a.inimigo_vivo_array = vec; bus_b.inimigo_vivo_array = vec;
    bus_a.perdeu  = perd;  bus_b.perdeu  = perd;
    bus_a.pausa   = pau;   bus_b.pausa   = pau;
    bus_a.iniciar = ini;   bus_b.iniciar = ini;
    bus_a.vidas   = vidas_cur; bus_b.vidas = vidas_cur;
    @(posedge clk);
    model(vec, perd, pau, ini, r);
    #1;
    compare_all();
  endtask

  // Entity-layer imitation: random kills, occasional partial respawn,
  // full respawn a little after a wave is cleared.
  logic [0:N-1] cur;
  task automatic evolve();
    if (cur == '0) begin
      if ($urandom_range(0, 2) == 0) cur = '1;
    end else begin
      cur = cur & N'($urandom);
      if ($urandom_range(0, 19) == 0) cur = cur | N'($urandom);
    end
  endtask

  initial begin
    int hi;
    rst = 1'b1;
    vidas_cur = 2'd0;
    bus_a.inimigo_vivo_array = '0; bus_b.inimigo_vivo_array = '0;
    bus_a.perdeu = 0; bus_b.perdeu = 0; bus_a.pausa = 0; bus_b.pausa = 0;
    bus_a.iniciar = 0; bus_b.iniciar = 0; bus_a.vidas = 0; bus_b.vidas = 0;

    // Reset state.
    step('1, 0, 0, 0, 1);
    step('1, 0, 0, 0, 1);
    check("rst_pontos", bus_a.pontos, 16'h0000);
    check("rst_nivel",  bus_a.nivel,  4'd1);
    check("rst_estado", bus_a.estado, 2'b00);

    // Single kill two cycles after the vector change.
    step(5'b11111); step(5'b11111);
    step(5'b11011); step(5'b11011);
    check("t1_pontos_a", bus_a.pontos, 16'h0001);
    check("t1_pontos_b", bus_b.pontos, 16'h0009);

    // Three kills at once.
    step(5'b10000); step(5'b10000);
    check("t2_pontos_a", bus_a.pontos, 16'h0004);
    check("t2_pontos_b", bus_b.pontos, 16'h0036);

    // Wave clear, then respawn.
    step(5'b00000); step(5'b00000);
    check("t3_nova",   bus_a.nova_onda, 1'b1);
    check("t3_nivel",  bus_a.nivel, 4'd2);
    check("t3_estado", bus_a.estado, 2'b01);
    step(5'b00000);
    check("t3_nova_off", bus_a.nova_onda, 1'b0);
    step(5'b11111); step(5'b11111); step(5'b11111);
    check("t3_estado_back", bus_a.estado, 2'b00);
    check("t3_pontos", bus_a.pontos, 16'h0005);

    // Last kill together with loss.
    step(5'b00001); step(5'b00001);
    step(5'b00000, 1); step(5'b00000);
    check("t4_estado", bus_a.estado, 2'b10);
    check("t4_pontos", bus_a.pontos, 16'h0010);
    check("t4_nova",   bus_a.nova_onda, 1'b0);
    step(5'b00000);
    check("t4_recorde_a", bus_a.recorde, 16'h0010);
    check("t4_recorde_b", bus_b.recorde, 16'h0090);

    // Restart pulse length.
    step(5'b00000, 0, 0, 1);
    check("t5_pontos", bus_a.pontos, 16'h0000);
    check("t5_nivel",  bus_a.nivel, 4'd1);
    hi = bus_a.reiniciarJogo ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      step(5'b11111);
      if (bus_a.reiniciarJogo) hi++;
    end
    check("t5_pulso_len", hi, PULSO);
    check("t5_estado", bus_a.estado, 2'b00);
    check("t5_pontos_respawn", bus_a.pontos, 16'h0000);

    // Kill during pause is discarded.
    step(5'b01111, 0, 1); step(5'b01111, 0, 1); step(5'b01111, 0, 1);
    step(5'b01111); step(5'b01111);
    check("t6_pausa", bus_a.pontos, 16'h0000);

    // Reset in the middle of the restart pulse.
    step(5'b11111, 1); step(5'b11111); step(5'b11111);
    step(5'b11111, 0, 0, 1); step(5'b11111);
    check("t6_rj_high", bus_a.reiniciarJogo, 1'b1);
    step(5'b11111, 0, 0, 0, 1);
    check("t6_rj_abort", bus_a.reiniciarJogo, 1'b0);
    check("t6_recorde",  bus_a.recorde, 16'h0000);

    // Long play without loss: drives the x9 instance into saturation.
    cur = '1;
    for (int c = 0; c < 5000; c++) begin
      evolve();
      step(cur, 0, $urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0);
    end
    check("sat_b", bus_b.pontos, 16'h9999);

    // Fully random play: losses, pauses, restarts, occasional reset.
    for (int c = 0; c < 3000; c++) begin
      evolve();
      step(cur, $urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 499) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
